// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   - byte_size encodings used on the load/store request interface
//   - responder FSM state encodings
//   - default data/address width
//   - laneEnable(): byte-enable mask for a given access size and byte lane
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int DMEM_XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_WORD    = 2'd0,
    SIZE_BYTE    = 2'd1,
    SIZE_HALF    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // A half access uses the upper half whenever lane bit 1 is set. Alignment
  // is checked elsewhere, so lane bit 0 is ignored for halves here.
  function automatic logic [3:0] laneEnable(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lane;
      SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_responder_ram_array.sv
// ---------------------------------------------------------------------------
// dmem_ram_array
// Word-organised data storage: DEPTH_WORDS x 32 bits, synchronous write with
// per-byte enables, combinational read. The array has no reset; its contents
// survive a responder reset.
// Ports:
//   clk      in   write clock, rising edge
//   i_we     in   write strobe
//   i_addr   in   word index (shared by read and write)
//   i_be     in   byte enables, bit n selects bits [8n+7:8n]
//   i_wdata  in   write data, already steered onto the byte lanes
//   o_rdata  out  full word at i_addr
// ---------------------------------------------------------------------------
module dmem_ram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the core's load/store interface. A level-held
// request is latched in IDLE, waits LATENCY cycles in ACCESS, performs the
// access (with byte/half/word lane steering, alignment and range checks) on
// the internal RAM, pulses the matching ready for one cycle in RESP, and then
// waits in RELEASE until the requester drops its enables.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   mem_addr         byte address of the request
//   mem_data         store data, right-justified
//   byte_size        0: word, 1: byte, 2: half, 3: illegal
//   mem_read_en      read request, held until mem_read_ready
//   mem_write_en     write request, held until mem_write_ready
//   mem_data_out     read data, zero-extended, right-justified
//   mem_read_ready   one-cycle read completion pulse
//   mem_write_ready  one-cycle write completion pulse
//   mem_err          one-cycle pulse with ready when the request was rejected
//   busy             high whenever the responder is not in IDLE
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int              XLEN        = DMEM_XLEN,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      byte_size,
  input  logic            mem_read_en,
  input  logic            mem_write_en,
  output logic [XLEN-1:0] mem_data_out,
  output logic            mem_read_ready,
  output logic            mem_write_ready,
  output logic            mem_err,
  output logic            busy
);

  localparam int              AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int              CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [XLEN-1:0] SPAN     = XLEN'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

  state_e          r_state;
  state_e          w_stateNext;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  size_e           r_size;
  logic            r_isRead;
  logic            r_isWrite;

  logic [XLEN-1:0] w_offset;
  logic [AW-1:0]   w_wordIdx;
  logic [1:0]      w_lane;
  logic            w_outOfRange;
  logic            w_misaligned;
  logic            w_protoErr;
  logic            w_reject;
  logic            w_accessDone;
  logic            w_ramWe;
  logic [3:0]      w_ramBe;
  logic [31:0]     w_wrData;
  logic [31:0]     w_ramRdata;
  logic [31:0]     w_rdData;

  // The subtraction wraps modulo 2^XLEN; an address below the base is caught
  // explicitly because its wrapped offset could otherwise look in range.
  assign w_offset     = r_addr - BASE_ADDR;
  assign w_wordIdx    = w_offset[AW+1:2];
  assign w_lane       = r_addr[1:0];
  assign w_outOfRange = (r_addr < BASE_ADDR) || (w_offset >= SPAN);
  assign w_misaligned = ((r_size == SIZE_HALF) && r_addr[0]) ||
                        ((r_size == SIZE_WORD) && (r_addr[1:0] != 2'b00));
  assign w_protoErr   = r_isRead && r_isWrite;
  assign w_reject     = w_outOfRange || w_misaligned ||
                        (r_size == SIZE_ILLEGAL) || w_protoErr;

  // The RAM is only ever written on the single edge that completes ACCESS,
  // so a reset at any earlier point leaves storage untouched.
  assign w_accessDone = (r_state == ST_ACCESS) && (r_cnt == '0);
  assign w_ramWe      = w_accessDone && r_isWrite && !w_reject;
  assign w_ramBe      = laneEnable(r_size, w_lane);
  assign busy         = (r_state != ST_IDLE);

  // Replicate store data onto every lane; the byte enables pick the target.
  always_comb begin
    w_wrData = r_data[31:0];
    case (r_size)
      SIZE_BYTE: w_wrData = {4{r_data[7:0]}};
      SIZE_HALF: w_wrData = {2{r_data[15:0]}};
      default:   w_wrData = r_data[31:0];
    endcase
  end

  // Pull the addressed byte or half down to bit 0 and zero-extend.
  always_comb begin
    w_rdData = '0;
    case (r_size)
      SIZE_BYTE: w_rdData = {24'd0, w_ramRdata[{w_lane, 3'b000} +: 8]};
      SIZE_HALF: w_rdData = {16'd0, w_ramRdata[{w_lane[1], 4'b0000} +: 16]};
      SIZE_WORD: w_rdData = w_ramRdata;
      default:   w_rdData = '0;
    endcase
  end

  dmem_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_addr  (w_wordIdx),
    .i_be    (w_ramBe),
    .i_wdata (w_wrData),
    .o_rdata (w_ramRdata)
  );

  // RELEASE only falls back to IDLE once both enables are low, so a request
  // still being held after its ready pulse is never taken a second time.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:    if (mem_read_en || mem_write_en) w_stateNext = ST_ACCESS;
      ST_ACCESS:  if (r_cnt == '0) w_stateNext = ST_RESP;
      ST_RESP:    w_stateNext = ST_RELEASE;
      ST_RELEASE: if (!mem_read_en && !mem_write_en) w_stateNext = ST_IDLE;
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  // Request latching, latency countdown and registered response outputs.
  // mem_data_out keeps its value after RESP; only ready/err are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_addr          <= '0;
      r_data          <= '0;
      r_size          <= SIZE_WORD;
      r_isRead        <= 1'b0;
      r_isWrite       <= 1'b0;
      mem_data_out    <= '0;
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      mem_err         <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        ST_IDLE: begin
          if (mem_read_en || mem_write_en) begin
            r_addr    <= mem_addr;
            r_data    <= mem_data;
            r_size    <= size_e'(byte_size);
            r_isRead  <= mem_read_en;
            r_isWrite <= mem_write_en;
            r_cnt     <= CNT_INIT;
          end
        end
        ST_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            mem_read_ready  <= r_isRead;
            mem_write_ready <= r_isWrite;
            mem_err         <= w_reject;
            mem_data_out    <= (r_isRead && !w_reject) ? XLEN'(w_rdData) : '0;
          end
        end
        ST_RESP: begin
          mem_read_ready  <= 1'b0;
          mem_write_ready <= 1'b0;
          mem_err         <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. The main instance uses LATENCY=1; every
// request pushes its expected response into a queue and a negedge monitor
// pops and compares whenever a ready pulse appears. A second instance with
// LATENCY=4 is used for response timing.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        err;
    logic [31:0] data;
  } exp_t;

  localparam logic [1:0] SZ_W = 2'd0;
  localparam logic [1:0] SZ_B = 2'd1;
  localparam logic [1:0] SZ_H = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] memAddr, memData, dataOut;
  logic [1:0]  byteSize;
  logic        readEn, writeEn, readReady, writeReady, memErr, busy;

  logic [31:0] latAddr, latData, latDataOut;
  logic [1:0]  latSize;
  logic        latReadEn, latWriteEn, latReadReady, latWriteReady, latErr, latBusy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t monExp;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr        (memAddr),
    .mem_data        (memData),
    .byte_size       (byteSize),
    .mem_read_en     (readEn),
    .mem_write_en    (writeEn),
    .mem_data_out    (dataOut),
    .mem_read_ready  (readReady),
    .mem_write_ready (writeReady),
    .mem_err         (memErr),
    .busy            (busy)
  );

  dmem_responder #(.LATENCY(4)) dutLat (
    .clk             (clk),
    .rst             (rst),
    .mem_addr        (latAddr),
    .mem_data        (latData),
    .byte_size       (latSize),
    .mem_read_en     (latReadEn),
    .mem_write_en    (latWriteEn),
    .mem_data_out    (latDataOut),
    .mem_read_ready  (latReadReady),
    .mem_write_ready (latWriteReady),
    .mem_err         (latErr),
    .busy            (latBusy)
  );

  // Single comparison point shared by the monitor and the directed steps.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Every ready pulse must match the oldest outstanding expectation; an
  // error flag without a ready pulse is always wrong.
  always @(negedge clk) begin
    if (!rst && (readReady || writeReady)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedReady: got rd=%b wr=%b, expected no response",
                 readReady, writeReady);
      end else begin
        monExp = sb.pop_front();
        checkOutput("readReady", 32'(readReady), 32'(monExp.rd));
        checkOutput("writeReady", 32'(writeReady), 32'(monExp.wr));
        checkOutput("memErr", 32'(memErr), 32'(monExp.err));
        if (monExp.rd) checkOutput("dataOut", dataOut, monExp.data);
      end
    end else if (!rst && memErr) begin
      checks++;
      errors++;
      $display("[TB] FAIL strayErr: got mem_err=1 without ready, expected 0");
    end
  end

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got busy=1 after 10 cycles, expected 0", name);
    end
  endtask

  // Issue one request on the main instance, hold it until ready (plus
  // holdExtra cycles), then drop the enables and wait for IDLE.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input logic expErr,
                               input logic [31:0] expData, input int holdExtra);
    exp_t e;
    bit   seen;
    e.rd   = rd;
    e.wr   = wr;
    e.err  = expErr;
    e.data = expData;
    sb.push_back(e);
    @(negedge clk);
    memAddr  = addr;
    memData  = data;
    byteSize = size;
    readEn   = rd;
    writeEn  = wr;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (readReady || writeReady) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout: got no ready for addr %h, expected a pulse", addr);
    end
    if (holdExtra > 0) begin
      repeat (holdExtra) @(negedge clk);
      checkOutput("holdBusy", 32'(busy), 32'd1);
    end
    readEn  = 1'b0;
    writeEn = 1'b0;
    waitIdle("stimIdle");
  endtask

  // Request on the LATENCY=4 instance; ready must show on the 5th negedge.
  task automatic runLatency(input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] expData);
    int n;
    @(negedge clk);
    latAddr    = addr;
    latData    = data;
    latSize    = SZ_W;
    latReadEn  = rd;
    latWriteEn = !rd;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (latReadReady || latWriteReady) n = i;
      else checkOutput("latBusy", 32'(latBusy), 32'd1);
    end
    checkOutput("latCycles", 32'(n), 32'd5);
    checkOutput("latErr", 32'(latErr), 32'd0);
    if (rd) checkOutput("latData", latDataOut, expData);
    latReadEn  = 1'b0;
    latWriteEn = 1'b0;
    n = 0;
    while (latBusy && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latIdle", 32'(latBusy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    memAddr = '0; memData = '0; byteSize = SZ_W; readEn = 1'b0; writeEn = 1'b0;
    latAddr = '0; latData = '0; latSize = SZ_W; latReadEn = 1'b0; latWriteEn = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("rstData", dataOut, 32'd0);
    checkOutput("rstReadReady", 32'(readReady), 32'd0);
    checkOutput("rstWriteReady", 32'(writeReady), 32'd0);
    checkOutput("rstErr", 32'(memErr), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstLatBusy", 32'(latBusy), 32'd0);
    rst = 1'b0;

    // Word write then read-back.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_W, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 32'hDEADBEEF, 0);

    // Byte and half lane steering over a cleared word.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, SZ_W, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h13, 32'h123456AA, SZ_B, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hFFFF1234, SZ_H, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 32'hAA001234, 0);
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, SZ_B, 1'b0, 32'h000000AA, 0);
    applyStimulus(1'b1, 1'b0, 32'h12, 32'h0, SZ_H, 1'b0, 32'h0000AA00, 0);
    applyStimulus(1'b1, 1'b0, 32'h11, 32'h0, SZ_B, 1'b0, 32'h00000012, 0);

    // Misaligned word read returns an error and zero data.
    applyStimulus(1'b1, 1'b0, 32'h11, 32'h0, SZ_W, 1'b1, 32'h0, 0);

    // Out-of-range write would alias word 0 if unchecked.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, SZ_W, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'h55555555, SZ_W, 1'b1, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0, 32'hCAFEF00D, 0);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, SZ_W, 1'b1, 32'h0, 0);

    // Illegal size and misaligned half leave storage unchanged.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, SZ_X, 1'b1, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h77777777, SZ_X, 1'b1, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h11, 32'h00009999, SZ_H, 1'b1, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 32'hAA001234, 0);

    // Enable held through RESP and one RELEASE cycle: a single pulse only.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 32'hAA001234, 2);

    // Both enables: both readies with error, no write.
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, SZ_W, 1'b1, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 32'hAA001234, 0);

    // Reset during ACCESS of a write aborts it without touching storage.
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h11112222, SZ_W, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, 32'h11112222, 0);
    @(negedge clk);
    memAddr = 32'h20; memData = 32'h99999999; byteSize = SZ_W; writeEn = 1'b1;
    @(negedge clk);
    checkOutput("preRstBusy", 32'(busy), 32'd1);
    rst = 1'b1;
    writeEn = 1'b0;
    #1;
    checkOutput("midRstData", dataOut, 32'd0);
    checkOutput("midRstReadReady", 32'(readReady), 32'd0);
    checkOutput("midRstWriteReady", 32'(writeReady), 32'd0);
    checkOutput("midRstErr", 32'(memErr), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, 32'h11112222, 0);

    // Response timing with LATENCY=4.
    runLatency(1'b0, 32'h40, 32'h0BADC0DE, 32'h0);
    runLatency(1'b1, 32'h40, 32'h0, 32'h0BADC0DE);

    repeat (3) @(negedge clk);
    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
